// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel quad packer.
package pixel_pkg;
  localparam int PIXEL_W = 24;
  localparam int GROUP_N = 4;
  localparam int QUAD_W  = PIXEL_W * GROUP_N;
  localparam int ACC_W   = (GROUP_N - 1) * PIXEL_W;

  typedef struct packed {
    logic [QUAD_W-1:0] data;
    logic              last;
    logic [1:0]        pad;
  } quad_t;

  // Place the n newest accumulated pixels in the high slots, zero the rest.
  function automatic logic [QUAD_W-1:0] pad_quad(input logic [ACC_W-1:0] acc,
                                                 input logic [1:0] n);
    case (n)
      2'd1:    return {acc[PIXEL_W-1:0], {(3*PIXEL_W){1'b0}}};
      2'd2:    return {acc[2*PIXEL_W-1:0], {(2*PIXEL_W){1'b0}}};
      2'd3:    return {acc, {PIXEL_W{1'b0}}};
      default: return '0;
    endcase
  endfunction
endpackage

// File: rtl/pixel_quad_packer_if.sv
// Quad-word valid/ready stream toward the next processing stage.
interface pixel_quad_packer_if;
  import pixel_pkg::*;

  logic [QUAD_W-1:0] pQuadData;
  logic              pQuadValid;
  logic              pQuadReady;
  logic              pQuadLast;
  logic [1:0]        pQuadPad;

  modport master (output pQuadData, output pQuadValid, output pQuadLast,
                  output pQuadPad, input pQuadReady);
  modport slave  (input pQuadData, input pQuadValid, input pQuadLast,
                  input pQuadPad, output pQuadReady);
endinterface

// File: rtl/quad_fifo.sv
// First-word-fall-through FIFO of quads; a push into a full FIFO succeeds
// only when a pop happens on the same edge.
module quad_fifo
  import pixel_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  quad_t din,
  input  logic  pop,
  output quad_t dout,
  output logic  empty,
  output logic  full
);
  localparam int AW = $clog2(FIFO_DEPTH);

  quad_t          mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           push_en;
  logic           pop_en;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);
  // Head is zeroed while empty so outputs read as zero after reset.
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Storage: data only, no reset needed since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/pixel_quad_packer.sv
// Packs four active pixels per quad word, tags/pads the final quad of each
// line and queues quads in a FWFT FIFO toward the consumer.
module pixel_quad_packer
  import pixel_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               PixelClk,
  input  logic               aRst,
  input  logic               pVDE,
  input  logic [PIXEL_W-1:0] pData,
  pixel_quad_packer_if.master quad,
  output logic               pOverflow,
  output logic [15:0]        pLineCnt
);
  // Stage 0: pixel accumulator (oldest pixel in the high slot).
  logic [ACC_W-1:0]  acc_p0;
  logic [1:0]        cnt_p0;
  // Stage 1: last full quad, waiting to learn whether it ends the line.
  logic [QUAD_W-1:0] stage_p1;
  logic              vld_p1;

  quad_t push_q;
  quad_t head_q;
  logic  push;
  logic  pop;
  logic  drop;
  logic  empty;
  logic  full;
  logic  quad_done;

  assign quad_done = pVDE && (cnt_p0 == 2'(GROUP_N - 1));
  assign pop       = quad.pQuadValid & quad.pQuadReady;
  assign drop      = push & full & ~pop;

  // Choose the single push of this edge: the staged quad, or a padded tail.
  always_comb begin
    push   = 1'b0;
    push_q = '0;
    if (vld_p1) begin
      push        = 1'b1;
      push_q.data = stage_p1;
      push_q.last = ~pVDE;
    end else if (!pVDE && cnt_p0 != 2'd0) begin
      push        = 1'b1;
      push_q.data = pad_quad(acc_p0, cnt_p0);
      push_q.last = 1'b1;
      push_q.pad  = 2'd0 - cnt_p0;
    end
  end

  // Pixel and quad data path, qualified by pVDE; control gates its use.
  always_ff @(posedge PixelClk) begin
    if (pVDE) acc_p0 <= {acc_p0[ACC_W-PIXEL_W-1:0], pData};
    if (quad_done) stage_p1 <= {acc_p0, pData};
  end

  // Control: pixel count, stage valid, sticky overflow and line counter.
  always_ff @(posedge PixelClk or posedge aRst) begin
    if (aRst) begin
      cnt_p0    <= '0;
      vld_p1    <= 1'b0;
      pOverflow <= 1'b0;
      pLineCnt  <= '0;
    end else begin
      cnt_p0 <= pVDE ? cnt_p0 + 2'd1 : 2'd0;
      vld_p1 <= quad_done;
      if (drop) pOverflow <= 1'b1;
      if (push && push_q.last && !drop) pLineCnt <= pLineCnt + 16'd1;
    end
  end

  quad_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (PixelClk),
    .rst   (aRst),
    .push  (push),
    .din   (push_q),
    .pop   (pop),
    .dout  (head_q),
    .empty (empty),
    .full  (full)
  );

  assign quad.pQuadValid = ~empty;
  assign quad.pQuadData  = head_q.data;
  assign quad.pQuadLast  = head_q.last;
  assign quad.pQuadPad   = head_q.pad;
endmodule

// File: tb/tb_pixel_quad_packer.sv
// Directed bench for pixel_quad_packer: per-cycle vector table plus
// hand-written overflow, same-edge push/pop and mid-line reset sequences.
module tb_pixel_quad_packer;
  import pixel_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        vde;
  logic [23:0] pix;
  logic        ovf;
  logic [15:0] lines;

  always #5 clk = ~clk;

  pixel_quad_packer_if qif ();

  pixel_quad_packer #(.FIFO_DEPTH(4)) dut (
    .PixelClk (clk),
    .aRst     (rst),
    .pVDE     (vde),
    .pData    (pix),
    .quad     (qif),
    .pOverflow(ovf),
    .pLineCnt (lines)
  );

  typedef struct {
    logic        vde;
    logic [23:0] pix;
    logic        vld;
    logic [95:0] q;
    logic        last;
    logic [1:0]  pad;
    logic [15:0] lines;
  } vec_t;

  vec_t vq[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] q4(input logic [23:0] a, input logic [23:0] b,
                                     input logic [23:0] c, input logic [23:0] d);
    return {a, b, c, d};
  endfunction

  task automatic addv(input logic v, input logic [23:0] p, input logic ev,
                      input logic [95:0] q, input logic l, input logic [1:0] pd,
                      input logic [15:0] ln);
    vec_t r;
    r.vde = v; r.pix = p; r.vld = ev; r.q = q; r.last = l; r.pad = pd; r.lines = ln;
    vq.push_back(r);
  endtask

  task automatic do_reset();
    vde = 1'b0;
    pix = '0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_line(input logic [23:0] base, input int n);
    for (int i = 1; i <= n; i++) begin
      vde = 1'b1;
      pix = base + 24'(i);
      step();
    end
    vde = 1'b0;
    pix = '0;
  endtask

  task automatic drain_check(input string tag, input logic [95:0] q, input logic l);
    chk({tag, "_valid"}, 96'(qif.pQuadValid), 96'(1));
    chk({tag, "_data"}, qif.pQuadData, q);
    chk({tag, "_last"}, 96'(qif.pQuadLast), 96'(l));
    step();
  endtask

  initial begin
    logic [23:0] p;
    rst = 1'b1;
    vde = 1'b0;
    pix = '0;
    qif.pQuadReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 96'(qif.pQuadValid), 96'(0));
    chk("rst_data", qif.pQuadData, 96'(0));
    chk("rst_last", 96'(qif.pQuadLast), 96'(0));
    chk("rst_pad", 96'(qif.pQuadPad), 96'(0));
    chk("rst_ovf", 96'(ovf), 96'(0));
    chk("rst_lines", 96'(lines), 96'(0));
    rst = 1'b0;
    step();

    // 8-pixel line
    for (int i = 1; i <= 4; i++) addv(1, 24'(i), 0, '0, 0, 0, 0);
    addv(1, 24'h5, 1, q4(1, 2, 3, 4), 0, 0, 0);
    for (int i = 6; i <= 8; i++) addv(1, 24'(i), 0, '0, 0, 0, 0);
    addv(0, 0, 1, q4(5, 6, 7, 8), 1, 0, 1);
    addv(0, 0, 0, '0, 0, 0, 1);
    // 6-pixel line
    for (int i = 0; i < 4; i++) addv(1, 24'h10 + 24'(i), 0, '0, 0, 0, 1);
    addv(1, 24'h14, 1, q4(24'h10, 24'h11, 24'h12, 24'h13), 0, 0, 1);
    addv(1, 24'h15, 0, '0, 0, 0, 1);
    addv(0, 0, 1, q4(24'h14, 24'h15, 0, 0), 1, 2, 2);
    addv(0, 0, 0, '0, 0, 0, 2);
    // single-cycle line
    addv(1, 24'hABCDEF, 0, '0, 0, 0, 2);
    addv(0, 0, 1, q4(24'hABCDEF, 0, 0, 0), 1, 3, 3);
    addv(0, 0, 0, '0, 0, 0, 3);
    // 5-pixel line
    for (int i = 0; i < 4; i++) addv(1, 24'h21 + 24'(i), 0, '0, 0, 0, 3);
    addv(1, 24'h25, 1, q4(24'h21, 24'h22, 24'h23, 24'h24), 0, 0, 3);
    addv(0, 0, 1, q4(24'h25, 0, 0, 0), 1, 3, 4);
    addv(0, 0, 0, '0, 0, 0, 4);
    // 3-pixel line
    for (int i = 0; i < 3; i++) addv(1, 24'h31 + 24'(i), 0, '0, 0, 0, 4);
    addv(0, 0, 1, q4(24'h31, 24'h32, 24'h33, 0), 1, 1, 5);
    addv(0, 0, 0, '0, 0, 0, 5);

    qif.pQuadReady = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      vde = vq[i].vde;
      pix = vq[i].pix;
      step();
      chk($sformatf("v%0d_valid", i), 96'(qif.pQuadValid), 96'(vq[i].vld));
      if (vq[i].vld) begin
        chk($sformatf("v%0d_data", i), qif.pQuadData, vq[i].q);
        chk($sformatf("v%0d_last", i), 96'(qif.pQuadLast), 96'(vq[i].last));
        chk($sformatf("v%0d_pad", i), 96'(qif.pQuadPad), 96'(vq[i].pad));
      end
      chk($sformatf("v%0d_lines", i), 96'(lines), 96'(vq[i].lines));
    end
    vde = 1'b0;

    // Overflow: 24-pixel line with consumer stalled
    do_reset();
    qif.pQuadReady = 1'b0;
    send_line(24'h100, 24);
    step();
    chk("ovf_flag", 96'(ovf), 96'(1));
    chk("ovf_lines", 96'(lines), 96'(0));
    qif.pQuadReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p = 24'h100 + 24'(4 * i);
      drain_check($sformatf("ovf_q%0d", i), q4(p + 1, p + 2, p + 3, p + 4), 1'b0);
    end
    chk("ovf_empty", 96'(qif.pQuadValid), 96'(0));
    chk("ovf_sticky", 96'(ovf), 96'(1));

    // Reset mid-line with two quads queued
    qif.pQuadReady = 1'b0;
    send_line(24'h400, 8);
    step();
    chk("rm_lines_pre", 96'(lines), 96'(1));
    chk("rm_valid_pre", 96'(qif.pQuadValid), 96'(1));
    vde = 1'b1; pix = 24'h501; step();
    pix = 24'h502; step();
    vde = 1'b0; pix = '0;
    #2 rst = 1'b1;
    #1;
    chk("rm_valid", 96'(qif.pQuadValid), 96'(0));
    chk("rm_data", qif.pQuadData, 96'(0));
    chk("rm_last", 96'(qif.pQuadLast), 96'(0));
    chk("rm_pad", 96'(qif.pQuadPad), 96'(0));
    chk("rm_ovf", 96'(ovf), 96'(0));
    chk("rm_lines", 96'(lines), 96'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    qif.pQuadReady = 1'b1;
    send_line(24'h600, 4);
    step();
    chk("rm_next_valid", 96'(qif.pQuadValid), 96'(1));
    chk("rm_next_data", qif.pQuadData, q4(24'h601, 24'h602, 24'h603, 24'h604));
    chk("rm_next_last", 96'(qif.pQuadLast), 96'(1));
    chk("rm_next_pad", 96'(qif.pQuadPad), 96'(0));
    chk("rm_next_lines", 96'(lines), 96'(1));
    step();
    chk("rm_next_empty", 96'(qif.pQuadValid), 96'(0));

    // Full FIFO: pop and push on the same edge
    do_reset();
    qif.pQuadReady = 1'b0;
    send_line(24'h300, 16);
    step();
    chk("se_lines1", 96'(lines), 96'(1));
    send_line(24'h200, 4);
    qif.pQuadReady = 1'b1;
    step();
    qif.pQuadReady = 1'b0;
    chk("se_ovf", 96'(ovf), 96'(0));
    chk("se_lines2", 96'(lines), 96'(2));
    qif.pQuadReady = 1'b1;
    drain_check("se_q1", q4(24'h305, 24'h306, 24'h307, 24'h308), 1'b0);
    drain_check("se_q2", q4(24'h309, 24'h30A, 24'h30B, 24'h30C), 1'b0);
    drain_check("se_q3", q4(24'h30D, 24'h30E, 24'h30F, 24'h310), 1'b1);
    drain_check("se_r0", q4(24'h201, 24'h202, 24'h203, 24'h204), 1'b1);
    chk("se_empty", 96'(qif.pQuadValid), 96'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
